// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory request FSM with timeout,
// load lane extraction/extension and the MEM/WB writeback register.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_load_inst,
  input  logic        in_store_inst,
  input  logic [1:0]  in_size,
  input  logic        in_load_u,
  input  logic [4:0]  in_dest_reg,
  input  logic        in_dest_reg_valid,
  input  logic        in_inval_dest_reg,
  output logic        stall,
  output logic [31:0] ex_mem_result,
  output logic [4:0]  ex_mem_dest_reg,
  output logic        ex_mem_dest_reg_valid,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_dest_reg,
  output logic        mem_wb_dest_reg_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic        m_valid;
  logic [31:0] m_result;
  logic [31:0] m_store_data;
  logic        m_load;
  logic        m_store;
  logic [1:0]  m_size;
  logic        m_load_u;
  logic [4:0]  m_dest_reg;
  logic        m_dest_reg_valid;
  logic        m_inval_dest_reg;

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  logic        is_load;
  logic        is_store;
  logic        aligned;
  logic        pending;
  logic        timeout;
  logic [31:0] load_data;

  // Select the addressed lane of the read word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(
    input logic [31:0] rdata,
    input logic [1:0]  offset,
    input logic [1:0]  size,
    input logic        zext
  );
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] result;
    shifted = rdata >> {offset, 3'b000};
    half    = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0: begin
        if (zext) begin
          result = {24'h000000, shifted[7:0]};
        end else begin
          result = {{24{shifted[7]}}, shifted[7:0]};
        end
      end
      2'd1: begin
        if (zext) begin
          result = {16'h0000, half};
        end else begin
          result = {{16{half[15]}}, half};
        end
      end
      default: result = rdata;
    endcase
    return result;
  endfunction

  // Access decode, handshake outputs and request formatting.
  always_comb begin
    is_load  = m_valid & m_load;
    // A simultaneous load flag wins, so the store is ignored.
    is_store = m_valid & m_store & ~m_load;
    case (m_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~m_result[0];
      default: aligned = (m_result[1:0] == 2'b00);
    endcase
    pending   = (is_load | is_store) & aligned;
    addr_err  = (is_load | is_store) & ~aligned;
    timeout   = pending & (state == ST_WAIT) & (cnt == TO_LAST) & ~dmem_ack;
    bus_err   = timeout;
    stall     = pending & ~dmem_ack & ~timeout;
    dmem_req  = pending;
    dmem_we   = is_store;
    dmem_addr = {m_result[31:2], 2'b00};
    if (pending) begin
      case (m_size)
        2'd0:    dmem_be = 4'b0001 << m_result[1:0];
        2'd1:    dmem_be = m_result[1] ? 4'b1100 : 4'b0011;
        default: dmem_be = 4'b1111;
      endcase
    end else begin
      dmem_be = 4'b0000;
    end
    case (m_size)
      2'd0:    dmem_wdata = {4{m_store_data[7:0]}};
      2'd1:    dmem_wdata = {2{m_store_data[15:0]}};
      default: dmem_wdata = m_store_data;
    endcase
    load_data = load_extend(dmem_rdata, m_result[1:0], m_size, m_load_u);
    ex_mem_result         = m_result;
    ex_mem_dest_reg       = m_dest_reg;
    // Loads are not forwarded from here; decode inserts the load-use bubble.
    ex_mem_dest_reg_valid = m_valid & m_dest_reg_valid & ~m_inval_dest_reg & ~m_load;
  end

  // EX/MEM register: captures EX output unless the stage is stalled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      m_valid          <= 1'b0;
      m_result         <= 32'h0000_0000;
      m_store_data     <= 32'h0000_0000;
      m_load           <= 1'b0;
      m_store          <= 1'b0;
      m_size           <= 2'b00;
      m_load_u         <= 1'b0;
      m_dest_reg       <= 5'd0;
      m_dest_reg_valid <= 1'b0;
      m_inval_dest_reg <= 1'b0;
    end else if (!stall) begin
      m_valid          <= in_valid;
      m_result         <= in_result;
      m_store_data     <= in_store_data;
      m_load           <= in_load_inst;
      m_store          <= in_store_inst;
      m_size           <= in_size;
      m_load_u         <= in_load_u;
      m_dest_reg       <= in_dest_reg;
      m_dest_reg_valid <= in_dest_reg_valid;
      m_inval_dest_reg <= in_inval_dest_reg;
    end
  end

  // Request FSM: IDLE issues, WAIT holds the request until ack or timeout.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending && !dmem_ack) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (!pending || dmem_ack || timeout) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: stall, error and store cycles write back as bubbles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_wb_result         <= 32'h0000_0000;
      mem_wb_dest_reg       <= 5'd0;
      mem_wb_dest_reg_valid <= 1'b0;
    end else begin
      mem_wb_result         <= m_load ? load_data : m_result;
      mem_wb_dest_reg       <= m_dest_reg;
      mem_wb_dest_reg_valid <= m_valid & m_dest_reg_valid & ~m_inval_dest_reg &
                               ~stall & ~addr_err & ~bus_err & ~is_store;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic        in_load_inst;
  logic        in_store_inst;
  logic [1:0]  in_size;
  logic        in_load_u;
  logic [4:0]  in_dest_reg;
  logic        in_dest_reg_valid;
  logic        in_inval_dest_reg;
  logic        stall;
  logic [31:0] ex_mem_result;
  logic [4:0]  ex_mem_dest_reg;
  logic        ex_mem_dest_reg_valid;
  logic [31:0] mem_wb_result;
  logic [4:0]  mem_wb_dest_reg;
  logic        mem_wb_dest_reg_valid;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        addr_err;
  logic        bus_err;

  always #5 clock = ~clock;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_result(in_result),
    .in_store_data(in_store_data), .in_load_inst(in_load_inst),
    .in_store_inst(in_store_inst), .in_size(in_size), .in_load_u(in_load_u),
    .in_dest_reg(in_dest_reg), .in_dest_reg_valid(in_dest_reg_valid),
    .in_inval_dest_reg(in_inval_dest_reg), .stall(stall),
    .ex_mem_result(ex_mem_result), .ex_mem_dest_reg(ex_mem_dest_reg),
    .ex_mem_dest_reg_valid(ex_mem_dest_reg_valid), .mem_wb_result(mem_wb_result),
    .mem_wb_dest_reg(mem_wb_dest_reg), .mem_wb_dest_reg_valid(mem_wb_dest_reg_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .addr_err(addr_err), .bus_err(bus_err)
  );

  typedef struct {
    bit        v;
    bit [31:0] res;
    bit [31:0] sd;
    bit        ld;
    bit        st;
    bit [1:0]  sz;
    bit        lu;
    bit [4:0]  dr;
    bit        dv;
    bit        inv;
  } inst_t;

  inst_t     mdl;
  int        waited;
  bit [31:0] wb_res;
  bit [4:0]  wb_dr;
  bit        wb_v;
  int        n_checks = 0;
  int        n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_aligned(input bit [1:0] sz, input bit [31:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic bit [3:0] exp_be(input bit [1:0] sz, input bit [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic bit [31:0] exp_wdata(input bit [1:0] sz, input bit [31:0] sd);
    if (sz == 2'd0) return (sd % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic bit [31:0] exp_load(input bit [1:0] sz, input bit [31:0] a,
                                         input bit lu, input bit [31:0] rd);
    int bits;
    int off;
    longint raw;
    bits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    off  = (sz == 2'd0) ? int'(a % 4) : (sz == 2'd1) ? int'((a % 4) / 2) * 2 : 0;
    raw  = longint'(rd / (64'd1 << (8 * off))) % (longint'(1) << bits);
    if (!lu && bits < 32 && raw >= (longint'(1) << (bits - 1)))
      raw = raw - (longint'(1) << bits);
    return 32'(raw);
  endfunction

  task automatic set_inst(input bit v, input bit [31:0] res, input bit [31:0] sd,
                          input bit ld, input bit st, input bit [1:0] sz, input bit lu,
                          input bit [4:0] dr, input bit dv, input bit inv);
    in_valid = v; in_result = res; in_store_data = sd; in_load_inst = ld;
    in_store_inst = st; in_size = sz; in_load_u = lu; in_dest_reg = dr;
    in_dest_reg_valid = dv; in_inval_dest_reg = inv;
  endtask

  task automatic bubble();
    set_inst(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic tick();
    bit ld, st, al, pend, aerr, tmo, stl;
    bit [31:0] lval;
    @(negedge clock);
    ld   = mdl.v && mdl.ld;
    st   = mdl.v && mdl.st && !mdl.ld;
    al   = is_aligned(mdl.sz, mdl.res);
    pend = (ld || st) && al;
    aerr = (ld || st) && !al;
    tmo  = pend && !dmem_ack && waited == TO;
    stl  = pend && !dmem_ack && !tmo;
    lval = exp_load(mdl.sz, mdl.res, mdl.lu, dmem_rdata);
    chk("stall", 32'(stall), 32'(stl));
    chk("dmem_req", 32'(dmem_req), 32'(pend));
    chk("dmem_we", 32'(dmem_we), 32'(st));
    chk("dmem_addr", dmem_addr, mdl.res - (mdl.res % 4));
    chk("dmem_be", 32'(dmem_be), pend ? 32'(exp_be(mdl.sz, mdl.res)) : 32'd0);
    chk("dmem_wdata", dmem_wdata, exp_wdata(mdl.sz, mdl.sd));
    chk("addr_err", 32'(addr_err), 32'(aerr));
    chk("bus_err", 32'(bus_err), 32'(tmo));
    chk("ex_mem_result", ex_mem_result, mdl.res);
    chk("ex_mem_dest_reg", 32'(ex_mem_dest_reg), 32'(mdl.dr));
    chk("ex_mem_dest_valid", 32'(ex_mem_dest_reg_valid),
        32'(mdl.v && mdl.dv && !mdl.inv && !mdl.ld));
    chk("mem_wb_result", mem_wb_result, wb_res);
    chk("mem_wb_dest_reg", 32'(mem_wb_dest_reg), 32'(wb_dr));
    chk("mem_wb_dest_valid", 32'(mem_wb_dest_reg_valid), 32'(wb_v));
    @(posedge clock);
    if (!reset_n) begin
      mdl    = '{default: 0};
      waited = 0;
      wb_res = 32'd0; wb_dr = 5'd0; wb_v = 1'b0;
    end else begin
      wb_v   = mdl.v && mdl.dv && !mdl.inv && !stl && !aerr && !tmo && !st;
      wb_res = mdl.ld ? lval : mdl.res;
      wb_dr  = mdl.dr;
      waited = stl ? waited + 1 : 0;
      if (!stl)
        mdl = '{v: in_valid, res: in_result, sd: in_store_data, ld: in_load_inst,
                st: in_store_inst, sz: in_size, lu: in_load_u, dr: in_dest_reg,
                dv: in_dest_reg_valid, inv: in_inval_dest_reg};
    end
    #1;
  endtask

  initial begin
    int stall_cnt;
    int berr_at;
    mdl = '{default: 0};
    waited = 0; wb_res = 32'd0; wb_dr = 5'd0; wb_v = 1'b0;
    reset_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    bubble();
    #1;
    tick(); tick();
    chk("reset_req", 32'(dmem_req), 32'd0);
    chk("reset_wb_valid", 32'(mem_wb_dest_reg_valid), 32'd0);
    reset_n = 1'b1;

    // Word load, ack in the same cycle.
    set_inst(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    bubble(); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk("t40_stall", 32'(stall), 32'd0);
    chk("t40_req", 32'(dmem_req), 32'd1);
    tick();
    chk("t40_wb_res", mem_wb_result, 32'hDEAD_BEEF);
    chk("t40_wb_dest", 32'(mem_wb_dest_reg), 32'd5);
    chk("t40_wb_valid", 32'(mem_wb_dest_reg_valid), 32'd1);

    // Signed and unsigned byte load at offset 3, ack after three waiting cycles.
    for (int u = 0; u < 2; u++) begin
      set_inst(1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, u[0], 5'd7, 1'b1, 1'b0);
      dmem_ack = 1'b0;
      tick();
      bubble(); dmem_rdata = 32'h8011_2233;
      for (int i = 0; i < 3; i++) begin
        #1;
        chk("t41_stall", 32'(stall), 32'd1);
        chk("t41_be", 32'(dmem_be), 32'h8);
        tick();
      end
      dmem_ack = 1'b1; #1;
      chk("t41_ack_stall", 32'(stall), 32'd0);
      tick();
      chk("t41_wb_res", mem_wb_result, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      dmem_ack = 1'b0;
    end

    // Half-word store at 0x202 that also claims a destination.
    set_inst(1'b1, 32'h202, 32'h0000_ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    bubble(); #1;
    chk("t42_addr", dmem_addr, 32'h200);
    chk("t42_be", 32'(dmem_be), 32'hC);
    chk("t42_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("t42_we", 32'(dmem_we), 32'd1);
    dmem_ack = 1'b1;
    tick();
    chk("t42_wb_valid", 32'(mem_wb_dest_reg_valid), 32'd0);
    dmem_ack = 1'b0;

    // Misaligned word load.
    set_inst(1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    bubble(); #1;
    chk("t43_addr_err", 32'(addr_err), 32'd1);
    chk("t43_req", 32'(dmem_req), 32'd0);
    chk("t43_stall", 32'(stall), 32'd0);
    tick();
    chk("t43_addr_err_gone", 32'(addr_err), 32'd0);
    chk("t43_wb_valid", 32'(mem_wb_dest_reg_valid), 32'd0);

    // Timeout with no ack, then the same with ack arriving in the timeout cycle.
    for (int late = 0; late < 2; late++) begin
      set_inst(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd6, 1'b1, 1'b0);
      dmem_ack = 1'b0;
      tick();
      bubble(); dmem_rdata = 32'h1357_9BDF;
      stall_cnt = 0; berr_at = -1;
      for (int i = 0; i < 5; i++) begin
        if (i == 4 && late == 1) dmem_ack = 1'b1;
        #1;
        stall_cnt += int'(stall);
        if (bus_err) berr_at = i;
        tick();
      end
      chk("t44_stall_cycles", 32'(stall_cnt), 32'd4);
      chk("t44_bus_err_cycle", 32'(berr_at), (late == 0) ? 32'd4 : 32'hFFFF_FFFF);
      chk("t44_wb_valid", 32'(mem_wb_dest_reg_valid), 32'(late));
      dmem_ack = 1'b0;
    end

    // ALU result with invalidated and with live destination.
    for (int inv = 1; inv >= 0; inv--) begin
      set_inst(1'b1, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd3, 1'b1, inv[0]);
      tick();
      bubble(); #1;
      chk("t45_ex_valid", 32'(ex_mem_dest_reg_valid), 32'(1 - inv));
      tick();
      chk("t45_wb_valid", 32'(mem_wb_dest_reg_valid), 32'(1 - inv));
    end

    // Reset while waiting for an ack.
    set_inst(1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    bubble();
    tick(); tick();
    reset_n = 1'b0;
    tick();
    chk("t45_rst_req", 32'(dmem_req), 32'd0);
    chk("t45_rst_berr", 32'(bus_err), 32'd0);
    chk("t45_rst_wb_valid", 32'(mem_wb_dest_reg_valid), 32'd0);
    reset_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bit [31:0] a;
      a = $urandom;
      if ($urandom_range(1, 0) == 0) a[1:0] = 2'b00;
      set_inst($urandom_range(3, 0) != 0, a, $urandom, 1'($urandom), 1'($urandom),
               2'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
               $urandom_range(4, 0) == 0);
      dmem_ack   = $urandom_range(2, 0) == 0;
      dmem_rdata = $urandom;
      reset_n    = $urandom_range(60, 0) != 0;
      tick();
    end
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
